// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - control and instruction-ROM signals of the fetch unit
interface pc_fetch_unit_if;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
  logic [31:0] fetch_cnt_o;
  logic        if_excp_adel_o;

  modport master (
    input  stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i, rom_inst_i,
    output rom_ce_o, rom_addr_o, if_pc_o, if_inst_o, if_valid_o, fetch_cnt_o, if_excp_adel_o
  );

  modport slave (
    output stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i, rom_inst_i,
    input  rom_ce_o, rom_addr_o, if_pc_o, if_inst_o, if_valid_o, fetch_cnt_o, if_excp_adel_o
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC owner and IF/ID register; FETCH_ALIGN_CHECK_EN enables misaligned-branch trap
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input logic               clk,
  input logic               rst,
  pc_fetch_unit_if.master   bus
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state, state_next;
  logic        rom_ce;
  logic [31:0] pc;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic [31:0] fetch_cnt;
  logic        excp;
  logic [31:0] branch_target;
  logic [31:0] new_pc;
  logic        misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
  assign branch_target = bus.branch_target_i;
  assign new_pc        = bus.new_pc_i;
  assign misaligned    = |bus.branch_target_i[1:0];
`else
  // Without the check, fetch addresses are always word aligned.
  assign branch_target = bus.branch_target_i & 32'hFFFF_FFFC;
  assign new_pc        = bus.new_pc_i & 32'hFFFF_FFFC;
  assign misaligned    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rom_ce     = 1'b0;
    case (state)
      S_IDLE: state_next = S_RUN;
      S_RUN:  rom_ce     = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      if_pc     <= 32'd0;
      if_inst   <= 32'd0;
      if_valid  <= 1'b0;
      fetch_cnt <= 32'd0;
      excp      <= 1'b0;
    end else if (rom_ce) begin
      if (bus.flush_i) begin
        pc       <= new_pc;
        if_valid <= 1'b0;
        if_inst  <= 32'd0;
        excp     <= 1'b0;
      end else if (!bus.stall_i) begin
        // Branches still capture the current word: it is the delay slot.
        if_pc     <= pc;
        if_inst   <= bus.rom_inst_i;
        if_valid  <= 1'b1;
        fetch_cnt <= fetch_cnt + 32'd1;
        if (bus.branch_flag_i) begin
          pc   <= misaligned ? EXC_VECTOR : branch_target;
          excp <= misaligned;
        end else begin
          pc   <= pc + 32'd4;
          excp <= 1'b0;
        end
      end
    end
  end

  assign bus.rom_ce_o       = rom_ce;
  assign bus.rom_addr_o     = pc;
  assign bus.if_pc_o        = if_pc;
  assign bus.if_inst_o      = if_inst;
  assign bus.if_valid_o     = if_valid;
  assign bus.fetch_cnt_o    = fetch_cnt;
  assign bus.if_excp_adel_o = excp;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - vector table, corner sequences and randomized model check for pc_fetch_unit
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  assign bus.rom_inst_i = rom_word(bus.rom_addr_o);

  typedef struct {
    logic        r, st, fl;
    logic [31:0] np;
    logic        br;
    logic [31:0] bt;
    logic        ce;
    logic [31:0] addr, ifpc;
    logic        v;
    logic [31:0] cnt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, st, fl, input logic [31:0] np, input logic br,
                     input logic [31:0] bt, input logic ce, input logic [31:0] addr,
                     input logic [31:0] ifpc, input logic v, input logic [31:0] cnt);
    vec_t x;
    x.r = r; x.st = st; x.fl = fl; x.np = np; x.br = br; x.bt = bt;
    x.ce = ce; x.addr = addr; x.ifpc = ifpc; x.v = v; x.cnt = cnt;
    tv.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic r, st, fl, input logic [31:0] np, input logic br,
                      input logic [31:0] bt);
    rst = r;
    bus.stall_i = st;
    bus.flush_i = fl;
    bus.new_pc_i = np;
    bus.branch_flag_i = br;
    bus.branch_target_i = bt;
    @(posedge clk);
    #1;
  endtask

  // Reference model: architectural state of the fetch stage as plain variables.
  logic        m_ce, m_v, m_ex;
  logic [31:0] m_pc, m_ifpc, m_inst, m_cnt;

  function automatic logic [31:0] fetch_addr(input logic [31:0] a);
    return ALIGN_CHECK ? a : {a[31:2], 2'b00};
  endfunction

  task automatic model_edge(input logic r, st, fl, input logic [31:0] np, input logic br,
                            input logic [31:0] bt);
    if (r) begin
      m_ce = 0; m_pc = RESET_PC; m_ifpc = 0; m_inst = 0; m_v = 0; m_cnt = 0; m_ex = 0;
    end else if (!m_ce) begin
      m_ce = 1;
    end else if (fl) begin
      m_pc = fetch_addr(np); m_v = 0; m_inst = 0; m_ex = 0;
    end else if (!st) begin
      m_ifpc = m_pc;
      m_inst = rom_word(m_pc);
      m_v    = 1;
      m_cnt  = m_cnt + 1;
      if (br && ALIGN_CHECK && bt[1:0] != 2'b00) begin
        m_pc = EXC_VECTOR; m_ex = 1;
      end else if (br) begin
        m_pc = fetch_addr(bt); m_ex = 0;
      end else begin
        m_pc = m_pc + 4; m_ex = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.stall_i = 0; bus.flush_i = 0; bus.new_pc_i = 0;
    bus.branch_flag_i = 0; bus.branch_target_i = 0;

    //  r  st fl new_pc        br target       ce addr          if_pc         v  cnt
    add(1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'h4,        32'h0,        1, 1);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'h8,        32'h4,        1, 2);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'hC,        32'h8,        1, 3);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'h10,       32'hC,        1, 4);
    add(0, 1, 0, 32'h0,        0, 32'h0,       1, 32'h10,       32'hC,        1, 4);
    add(0, 1, 0, 32'h0,        0, 32'h0,       1, 32'h10,       32'hC,        1, 4);
    add(0, 1, 0, 32'h0,        0, 32'h0,       1, 32'h10,       32'hC,        1, 4);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'h14,       32'h10,       1, 5);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'h18,       32'h14,       1, 6);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'h1C,       32'h18,       1, 7);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'h20,       32'h1C,       1, 8);
    add(0, 0, 0, 32'h0,        1, 32'h100,     1, 32'h100,      32'h20,       1, 9);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'h104,      32'h100,      1, 10);
    add(0, 1, 1, 32'h20,       0, 32'h0,       1, 32'h20,       32'h100,      0, 10);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'h24,       32'h20,       1, 11);
    add(0, 1, 0, 32'h0,        1, 32'h200,     1, 32'h24,       32'h20,       1, 11);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'h28,       32'h24,       1, 12);
    add(0, 0, 1, 32'h40,       0, 32'h0,       1, 32'h40,       32'h24,       0, 12);
    add(0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,       1, 32'hFFFFFFFC, 32'h24,       0, 12);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'h0,        32'hFFFFFFFC, 1, 13);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'h4,        32'h0,        1, 14);
    add(1, 0, 0, 32'h0,        1, 32'h300,     0, 32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'h0,        32'h0,        0, 0);
    add(0, 0, 1, 32'h80,       0, 32'h0,       1, 32'h80,       32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'h84,       32'h80,       1, 1);
    add(0, 0, 1, 32'h60,       1, 32'h500,     1, 32'h60,       32'h80,       0, 1);
    add(0, 0, 0, 32'h0,        0, 32'h0,       1, 32'h64,       32'h60,       1, 2);

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].r, tv[i].st, tv[i].fl, tv[i].np, tv[i].br, tv[i].bt);
      chk($sformatf("vec%0d ce", i),    {31'd0, bus.rom_ce_o},       {31'd0, tv[i].ce});
      chk($sformatf("vec%0d addr", i),  bus.rom_addr_o,              tv[i].addr);
      chk($sformatf("vec%0d if_pc", i), bus.if_pc_o,                 tv[i].ifpc);
      chk($sformatf("vec%0d valid", i), {31'd0, bus.if_valid_o},     {31'd0, tv[i].v});
      chk($sformatf("vec%0d cnt", i),   bus.fetch_cnt_o,             tv[i].cnt);
      chk($sformatf("vec%0d inst", i),  bus.if_inst_o,
          tv[i].v ? rom_word(tv[i].ifpc) : 32'd0);
      chk($sformatf("vec%0d excp", i),  {31'd0, bus.if_excp_adel_o}, 32'd0);
    end

    // Misaligned branch target from pc=0x64.
    step(0, 0, 0, 32'h0, 1, 32'h102);
    chk("mis if_pc", bus.if_pc_o, 32'h64);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis addr", bus.rom_addr_o, EXC_VECTOR);
    chk("mis excp", {31'd0, bus.if_excp_adel_o}, 32'd1);
    step(0, 0, 0, 32'h0, 0, 32'h0);
    chk("mis excp clr", {31'd0, bus.if_excp_adel_o}, 32'd0);
    chk("mis next if_pc", bus.if_pc_o, EXC_VECTOR);
`else
    chk("mis addr", bus.rom_addr_o, 32'h100);
    chk("mis excp", {31'd0, bus.if_excp_adel_o}, 32'd0);
    step(0, 0, 0, 32'h0, 0, 32'h0);
    chk("mis excp clr", {31'd0, bus.if_excp_adel_o}, 32'd0);
    chk("mis next if_pc", bus.if_pc_o, 32'h100);
`endif

    // Randomized run against the model, starting from reset.
    model_edge(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 32'h0, 0, 32'h0);
    for (int c = 0; c < 400; c++) begin
      logic        r, st, fl, br;
      logic [31:0] np, bt;
      r  = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      br = ($urandom_range(0, 4) == 0);
      np = $urandom;
      bt = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      model_edge(r, st, fl, np, br, bt);
      step(r, st, fl, np, br, bt);
      chk($sformatf("rnd%0d ce", c),    {31'd0, bus.rom_ce_o},       {31'd0, m_ce});
      chk($sformatf("rnd%0d addr", c),  bus.rom_addr_o,              m_pc);
      chk($sformatf("rnd%0d if_pc", c), bus.if_pc_o,                 m_ifpc);
      chk($sformatf("rnd%0d inst", c),  bus.if_inst_o,               m_inst);
      chk($sformatf("rnd%0d valid", c), {31'd0, bus.if_valid_o},     {31'd0, m_v});
      chk($sformatf("rnd%0d cnt", c),   bus.fetch_cnt_o,             m_cnt);
      chk($sformatf("rnd%0d excp", c),  {31'd0, bus.if_excp_adel_o}, {31'd0, m_ex});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
